// File: rtl/sr_cmd_debouncer.sv
// sr_cmd_debouncer: turns two bouncy buttons into clean, mutually exclusive s/r command pulses
module sr_cmd_debouncer #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 8,
   parameter int PULSE_LEN       = 1,
   parameter int GAP_LEN         = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic set_btn,
   input  logic rst_btn,
   output logic s,
   output logic r,
   output logic busy,
   output logic conflict
);
   localparam int TMAX = PULSE_LEN > GAP_LEN ? PULSE_LEN : GAP_LEN;
   localparam int TW   = TMAX > 1 ? $clog2(TMAX) : 1;
   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0]    P_LAST  = TW'(PULSE_LEN - 1);
   localparam logic [TW-1:0]    G_LAST  = TW'(GAP_LEN - 1);

   typedef enum logic [1:0] {IDLE, SET, RST, GAP} state_t;

   // channel index 0 = set button, 1 = reset button
   logic [1:0]       meta_q, sync_q, stable_q, rise_d;
   logic [CNT_W-1:0] cnt_q [2];
   logic             pend_s_q, pend_r_q, pend_s_d, pend_r_d, conflict_d;
   logic             take_s, take_r, idle_conf;
   state_t           state_q;
   logic [TW-1:0]    tcnt_q;
   logic             s_q, r_q, busy_q, conflict_q;

   // two-flop synchroniser followed by a per-channel stability counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta_q   <= '0;
         sync_q   <= '0;
         stable_q <= '0;
         for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
      end else begin
         meta_q <= {rst_btn, set_btn};
         sync_q <= meta_q;
         for (int i = 0; i < 2; i++) begin
            if (sync_q[i] == stable_q[i]) cnt_q[i] <= '0;
            else if (cnt_q[i] == DB_LAST) begin
               stable_q[i] <= sync_q[i];
               cnt_q[i]    <= '0;
            end else cnt_q[i] <= cnt_q[i] + 1'b1;
         end
      end
   end

   // accepted rising edges and pending-request arbitration (conflict drops both, last request wins)
   always_comb begin
      rise_d     = sync_q & ~stable_q & {cnt_q[1] == DB_LAST, cnt_q[0] == DB_LAST};
      idle_conf  = state_q == IDLE && pend_s_q && pend_r_q;
      take_s     = state_q == IDLE && pend_s_q && !pend_r_q;
      take_r     = state_q == IDLE && pend_r_q && !pend_s_q;
      conflict_d = (&rise_d) || idle_conf;
      pend_s_d   = conflict_d ? 1'b0 : rise_d[0] ? 1'b1 : rise_d[1] ? 1'b0 : pend_s_q && !take_s;
      pend_r_d   = conflict_d ? 1'b0 : rise_d[1] ? 1'b1 : rise_d[0] ? 1'b0 : pend_r_q && !take_r;
   end

   // command sequencer IDLE -> SET/RST pulse -> GAP -> IDLE with registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         tcnt_q     <= '0;
         s_q        <= 1'b0;
         r_q        <= 1'b0;
         busy_q     <= 1'b0;
         conflict_q <= 1'b0;
         pend_s_q   <= 1'b0;
         pend_r_q   <= 1'b0;
      end else begin
         pend_s_q   <= pend_s_d;
         pend_r_q   <= pend_r_d;
         conflict_q <= conflict_d;
         case (state_q)
            IDLE: begin
               tcnt_q <= '0;
               if (take_s) begin
                  state_q <= SET;
                  s_q     <= 1'b1;
                  busy_q  <= 1'b1;
               end else if (take_r) begin
                  state_q <= RST;
                  r_q     <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            SET, RST: begin
               if (tcnt_q == P_LAST) begin
                  state_q <= GAP;
                  s_q     <= 1'b0;
                  r_q     <= 1'b0;
                  tcnt_q  <= '0;
               end else tcnt_q <= tcnt_q + 1'b1;
            end
            GAP: begin
               if (tcnt_q == G_LAST) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  tcnt_q  <= '0;
               end else tcnt_q <= tcnt_q + 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign s        = s_q;
   assign r        = r_q;
   assign busy     = busy_q;
   assign conflict = conflict_q;
endmodule
